spi_flash_resp: RTL and testbench
=================================

Name: spi_flash_resp

Overview:
- Single-lane SPI mode-0 responder: the target end of the SPI link that the mcu flash interface initiates.
- Emulates the flash commands the boot and ISP paths issue: 9Fh JDID, 05h RDSR, 03h READ.
- Array contents come from a synchronous memory read port. Used as a synthesizable flash stand-in for FPGA bring-up and fast benches.
- Oversampled: sclk, cs_n and si are synchronized into clk. Requires clk ≥ 4× sclk.

Parameters:
- AW, 24, byte-address width of the READ address; also the number of address bits shifted in.
- JDID, 24'h016017, 3-byte JEDEC ID returned MSB-first for 9Fh.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- sclk  in  1  SPI clock from initiator, asynchronous.
- cs_n  in  1  chip select, active low, asynchronous.
- si  in  1  serial data in (initiator qd[0]), asynchronous.
- so  out  1  serial data out (qd[1]).
- so_oe  out  1  output enable for so; tristate is done outside the block.
- status  in  8  value returned by RDSR.
- mem_addr  out  AW  byte address for array read.
- mem_rd  out  1  one-cycle read strobe.
- mem_data  in  8  read data, valid the cycle after mem_rd.
- busy  out  1  high while cs_n (synchronized) is low.

Behaviour:
- Reset values: so=1, so_oe=0, mem_rd=0, mem_addr=0, busy=0, state=IDLE. Synchronizer flops reset to sclk=0, cs_n=1, si=1.
- Sync: 2-FF synchronizer on sclk, cs_n, si, plus one history flop on sclk.
  - rise = s_sclk & ~h_sclk; fall = ~s_sclk & h_sclk.
  - Edge-to-action latency is 3 clk, equal for all three inputs.
- Bit timing:
  - si is sampled into shreg on rise.
  - so = txreg[7] is updated on fall. txreg shifts left on each fall after the first bit of a byte is presented.
  - A bit counter (3 bits) increments on rise and wraps 7→0 at each byte boundary.
- States:
  - IDLE: s_cs_n=1. On s_cs_n falling → CMD, bitcnt=0, so_oe=0.
  - CMD: on the 8th rise, decode the opcode.
    - 9Fh: load txreg=JDID[23:16], → DATA, mode=ID, idx=1.
    - 05h: load txreg=status, → DATA, mode=SR.
    - 03h: → ADDR, addr counter cleared.
    - Any other opcode: → IGNORE.
  - ADDR: shift AW bits MSB-first into addr. On the last rise: mem_addr=addr, mem_rd=1 for one cycle, → FETCH.
  - FETCH: the next clk loads txreg=mem_data, then → DATA with mode=RD. The fetch completes before the following fall because clk ≥ 4× sclk.
  - DATA:
    - so_oe=1 from the first fall in DATA onward. so presents txreg[7] on each fall.
    - On the 8th rise of each byte, load the next byte:
      - ID: JDID[15:8], then JDID[7:0], then FFh forever.
      - SR: re-sample status on every byte, so polling shows live WIP.
      - RD: mem_addr+1 mod 2^AW, mem_rd pulse, txreg loaded from mem_data next clk.
  - IGNORE: so_oe=0, all edges ignored until cs_n rises.
- Abort: s_cs_n=1 in any state → IDLE in the same cycle; so_oe=0 and so=1 the next cycle.
  - A partial byte is discarded; no mem_rd is issued after abort.
- Simultaneous events: if s_cs_n rises in the same cycle as rise or fall, the cs_n rise wins.
- Address wrap: FFFFFFh+1 → 000000h (for AW=24), with no gap in the stream.
- rst asserted mid-transaction: all state returns to reset values. A transaction in progress is ignored until cs_n goes high and then low again; IDLE requires s_cs_n=1 to re-arm.
- sclk activity while cs_n is high is ignored.

Decomposition:
- Package spi_flash_pkg:
  - Opcode constants OP_RDID=8'h9F, OP_RDSR=8'h05, OP_READ=8'h03.
  - State enum IDLE/CMD/ADDR/FETCH/DATA/IGNORE.
  - Mode enum ID/SR/RD.
- Sub-module spi_sync: 2-FF synchronizers plus rise/fall detect for sclk, and sync for cs_n and si.

Test Plan:
- JDID: cs low, send 9Fh, clock 24 bits → so yields 01h 60h 17h; 4th byte is FFh; so_oe=1 only after the 8th fall.
- RDSR polling: status=03h, send 05h, read 1 byte → 03h. Change status to 00h mid-transaction, read next byte → 00h; no cs_n toggle needed.
- READ: mem model returns addr[7:0]; send 03h 00h 00h 10h, clock 3 bytes → 10h 11h 12h; mem_rd pulses exactly 3 times, mem_addr 000010h..000012h.
- Wrap: READ at FFFFFEh, 3 bytes → FEh FFh 00h; mem_addr sequence FFFFFEh, FFFFFFh, 000000h.
- Unknown opcode and abort:
  - Send ABh, clock 16 more bits → so_oe stays 0.
  - Raise cs_n after 4 bits of a 9Fh; the next transaction with full 9Fh → 01h 60h 17h.
- Reset mid-READ: assert rst for 1 clk during the address phase → outputs at reset values next cycle, no further mem_rd. After cs_n high/low, a new 05h returns status.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared opcodes and state encodings for the SPI flash responder.
// Pure declarations; no latency or flow control of its own.
package spi_flash_pkg;

    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_READ = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        FETCH,
        DATA,
        IGNORE
    } state_t;

    typedef enum logic [1:0] {
        ID,
        SR,
        RD
    } mode_t;

endpackage

// File: rtl/spi_sync.sv
// Brings sclk, cs_n and si into the clk domain and flags sclk edges.
// All three outputs lag their pins by the same 2 clk; no backpressure.
module spi_sync (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic cs_n,
    input  logic si,
    output logic s_cs_n,
    output logic s_si,
    output logic sclk_rise,
    output logic sclk_fall
);

    logic sclk_m_q, sclk_s_q, sclk_h_q;
    logic cs_m_q, cs_s_q;
    logic si_m_q, si_s_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_m_q <= 1'b0;
            sclk_s_q <= 1'b0;
            sclk_h_q <= 1'b0;
            cs_m_q   <= 1'b1;
            cs_s_q   <= 1'b1;
            si_m_q   <= 1'b1;
            si_s_q   <= 1'b1;
        end else begin
            sclk_m_q <= sclk;
            sclk_s_q <= sclk_m_q;
            sclk_h_q <= sclk_s_q;
            cs_m_q   <= cs_n;
            cs_s_q   <= cs_m_q;
            si_m_q   <= si;
            si_s_q   <= si_m_q;
        end
    end

    assign s_cs_n    = cs_s_q;
    assign s_si      = si_s_q;
    assign sclk_rise = sclk_s_q & ~sclk_h_q;
    assign sclk_fall = ~sclk_s_q & sclk_h_q;

endmodule

// File: rtl/spi_flash_resp.sv
// SPI mode-0 flash responder (9Fh JDID, 05h RDSR, 03h READ) backed by a sync memory port.
// Pin edge to action is 3 clk; the initiator paces everything, no backpressure.
module spi_flash_resp #(
    parameter int          AW   = 24,
    parameter logic [23:0] JDID = 24'h016017
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sclk,
    input  logic          cs_n,
    input  logic          si,
    output logic          so,
    output logic          so_oe,
    input  logic [7:0]    status,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [7:0]    mem_data,
    output logic          busy
);
    import spi_flash_pkg::*;

    localparam int ACW = $clog2(AW);

    logic s_cs_n, s_si, rise, fall;

    spi_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .si        (si),
        .s_cs_n    (s_cs_n),
        .s_si      (s_si),
        .sclk_rise (rise),
        .sclk_fall (fall)
    );

    state_t          state_q, state_d;
    mode_t           mode_q, mode_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [ACW-1:0]  addr_cnt_q, addr_cnt_d;
    logic [6:0]      shreg_q, shreg_d;
    logic [AW-2:0]   addr_q, addr_d;
    logic [7:0]      txreg_q, txreg_d;
    logic [1:0]      idx_q, idx_d;
    logic            so_q, so_d;
    logic            so_oe_q, so_oe_d;
    logic            mem_rd_q, mem_rd_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic            rd_dly_q, rd_dly_d;
    logic [1:0]      arm_cnt_q, arm_cnt_d;

    logic [7:0]      opcode;
    logic [AW-1:0]   addr_nxt;
    logic [7:0]      tx_cur;

    assign opcode   = {shreg_q, s_si};
    assign addr_nxt = {addr_q, s_si};
    // Memory data lands the cycle after the strobe; a fall in that same cycle must see it.
    assign tx_cur   = rd_dly_q ? mem_data : txreg_q;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        bitcnt_d   = bitcnt_q;
        addr_cnt_d = addr_cnt_q;
        shreg_d    = shreg_q;
        addr_d     = addr_q;
        txreg_d    = txreg_q;
        idx_d      = idx_q;
        so_d       = so_q;
        so_oe_d    = so_oe_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        rd_dly_d   = mem_rd_q;
        arm_cnt_d  = arm_cnt_q;

        if (rd_dly_q) txreg_d = mem_data;

        if (s_cs_n && state_q != IDLE) begin
            state_d   = IDLE;
            so_d      = 1'b1;
            so_oe_d   = 1'b0;
            arm_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    so_d    = 1'b1;
                    so_oe_d = 1'b0;
                    // cs_n must be seen high for several clk so a reset mid-transfer cannot re-arm.
                    if (s_cs_n) begin
                        if (arm_cnt_q != 2'd3) arm_cnt_d = arm_cnt_q + 2'd1;
                    end else begin
                        arm_cnt_d = '0;
                        if (arm_cnt_q == 2'd3) begin
                            state_d  = CMD;
                            bitcnt_d = '0;
                        end
                    end
                end
                CMD: begin
                    if (rise) begin
                        shreg_d  = opcode[6:0];
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            case (opcode)
                                OP_RDID: begin
                                    txreg_d = JDID[23:16];
                                    mode_d  = ID;
                                    idx_d   = 2'd1;
                                    state_d = DATA;
                                end
                                OP_RDSR: begin
                                    txreg_d = status;
                                    mode_d  = SR;
                                    state_d = DATA;
                                end
                                OP_READ: begin
                                    addr_d     = '0;
                                    addr_cnt_d = '0;
                                    mode_d     = RD;
                                    state_d    = ADDR;
                                end
                                default: state_d = IGNORE;
                            endcase
                        end
                    end
                end
                ADDR: begin
                    if (rise) begin
                        addr_d     = addr_nxt[AW-2:0];
                        addr_cnt_d = addr_cnt_q + 1'b1;
                        if (addr_cnt_q == ACW'(AW - 1)) begin
                            mem_addr_d = addr_nxt;
                            mem_rd_d   = 1'b1;
                            bitcnt_d   = '0;
                            state_d    = FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (rd_dly_q) state_d = DATA;
                end
                DATA: begin
                    if (rise) begin
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            case (mode_q)
                                ID: begin
                                    txreg_d = (idx_q == 2'd1) ? JDID[15:8] :
                                              (idx_q == 2'd2) ? JDID[7:0]  : 8'hFF;
                                    if (idx_q != 2'd3) idx_d = idx_q + 2'd1;
                                end
                                SR: txreg_d = status;
                                default: begin
                                    mem_addr_d = mem_addr_q + AW'(1);
                                    mem_rd_d   = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                IGNORE: ;
                default: state_d = IDLE;
            endcase

            if (fall && (state_q == DATA || (state_q == FETCH && rd_dly_q))) begin
                so_d    = tx_cur[7];
                so_oe_d = 1'b1;
                txreg_d = {tx_cur[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= ID;
            bitcnt_q   <= '0;
            addr_cnt_q <= '0;
            shreg_q    <= '0;
            addr_q     <= '0;
            txreg_q    <= '0;
            idx_q      <= '0;
            so_q       <= 1'b1;
            so_oe_q    <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            rd_dly_q   <= 1'b0;
            arm_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            bitcnt_q   <= bitcnt_d;
            addr_cnt_q <= addr_cnt_d;
            shreg_q    <= shreg_d;
            addr_q     <= addr_d;
            txreg_q    <= txreg_d;
            idx_q      <= idx_d;
            so_q       <= so_d;
            so_oe_q    <= so_oe_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            rd_dly_q   <= rd_dly_d;
            arm_cnt_q  <= arm_cnt_d;
        end
    end

    assign so       = so_q;
    assign so_oe    = so_oe_q;
    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign busy     = ~s_cs_n;

endmodule

// File: tb/tb_spi_flash_resp.sv
// Directed bench for spi_flash_resp: a mode-0 initiator drives the pins, and
// scoreboard queues of expected bytes and memory addresses are drained by monitors.
module tb_spi_flash_resp;

    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          rst, sclk, cs_n, si;
    logic          so, so_oe, mem_rd, busy;
    logic [7:0]    status;
    logic [7:0]    mem_data = 8'h00;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    spi_flash_resp #(.AW(AW), .JDID(24'h016017)) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .si       (si),
        .so       (so),
        .so_oe    (so_oe),
        .status   (status),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_data (mem_data),
        .busy     (busy)
    );

    // Synchronous array model: each byte holds the low byte of its address.
    always @(posedge clk) if (mem_rd) mem_data <= mem_addr[7:0];

    int checks = 0;
    int fails  = 0;
    logic [7:0]    exp_rx_q[$];
    logic [AW-1:0] exp_addr_q[$];
    bit  rx_en   = 1'b0;
    bit  ign_win = 1'b0;
    int  oe_hits = 0;
    int  mem_rd_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Receive monitor: assembles so at each sclk rise during data phases.
    logic [7:0] rx_sh = 8'h00;
    int  rx_bits = 0;
    bit  oe_ok = 1'b1;
    always @(posedge sclk) begin
        if (!rx_en) begin
            rx_bits = 0;
        end else begin
            if (rx_bits == 0) oe_ok = 1'b1;
            rx_sh = {rx_sh[6:0], so};
            oe_ok = oe_ok & (so_oe === 1'b1);
            rx_bits++;
            if (rx_bits == 8) begin
                rx_bits = 0;
                if (exp_rx_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL rx_extra: got byte %02h, none expected", rx_sh);
                end else begin
                    chk("rx_byte", 32'(rx_sh), 32'(exp_rx_q.pop_front()));
                    chk("rx_so_oe", 32'(oe_ok), 32'(1));
                end
            end
        end
    end

    // Memory-port monitor: every strobe must match the next expected address.
    always @(negedge clk) begin
        if (mem_rd === 1'b1) begin
            mem_rd_cnt++;
            if (exp_addr_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL mem_rd_extra: got strobe at %06h, none expected", mem_addr);
            end else begin
                chk("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
            end
        end
        if (ign_win && so_oe === 1'b1) oe_hits++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One mode-0 bit; on the last bit cs_n rises together with sclk.
    task automatic spi_bit(input logic b, input bit last);
        si = b;
        wait_clk(8);
        sclk = 1'b1;
        if (last) cs_n = 1'b1;
        wait_clk(8);
        sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b, input bit last);
        for (int i = 7; i >= 0; i--) spi_bit(b[i], last && (i == 0));
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        wait_clk(8);
    endtask

    task automatic idle_gap();
        rx_en = 1'b0;
        cs_n  = 1'b1;
        wait_clk(16);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_so"}, 32'(so), 32'(1));
        chk({tag, "_so_oe"}, 32'(so_oe), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int rd_base;

    initial begin
        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; si = 1'b1; status = 8'h00;
        wait_clk(4);
        check_idle_outputs("reset");
        chk("reset_mem_rd", 32'(mem_rd), 32'(0));
        chk("reset_mem_addr", 32'(mem_addr), 32'(0));
        rst = 1'b0;
        wait_clk(8);

        // JDID with one trailing filler byte; so_oe rises only after the 8th fall.
        exp_rx_q.push_back(8'h01); exp_rx_q.push_back(8'h60);
        exp_rx_q.push_back(8'h17); exp_rx_q.push_back(8'hFF);
        cs_low();
        chk("jdid_busy", 32'(busy), 32'(1));
        spi_byte(8'h9F, 1'b0);
        chk("jdid_oe_before_fall8", 32'(so_oe), 32'(0));
        rx_en = 1'b1;
        wait_clk(5);
        chk("jdid_oe_after_fall8", 32'(so_oe), 32'(1));
        spi_byte(8'h00, 1'b0); spi_byte(8'h00, 1'b0);
        spi_byte(8'h00, 1'b0); spi_byte(8'h00, 1'b1);
        idle_gap();
        check_idle_outputs("jdid_end");

        // RDSR polling: status drops mid-byte, the next byte shows it.
        status = 8'h03;
        exp_rx_q.push_back(8'h03); exp_rx_q.push_back(8'h00);
        cs_low();
        spi_byte(8'h05, 1'b0);
        rx_en = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(1'b0, 1'b0);
            if (i == 4) status = 8'h00;
        end
        spi_byte(8'h00, 1'b1);
        idle_gap();

        // READ at 000010h, three bytes.
        rd_base = mem_rd_cnt;
        exp_rx_q.push_back(8'h10); exp_rx_q.push_back(8'h11); exp_rx_q.push_back(8'h12);
        exp_addr_q.push_back(24'h000010); exp_addr_q.push_back(24'h000011);
        exp_addr_q.push_back(24'h000012);
        cs_low();
        spi_byte(8'h03, 1'b0); spi_byte(8'h00, 1'b0);
        spi_byte(8'h00, 1'b0); spi_byte(8'h10, 1'b0);
        rx_en = 1'b1;
        spi_byte(8'h00, 1'b0); spi_byte(8'h00, 1'b0); spi_byte(8'h00, 1'b1);
        idle_gap();
        chk("read_mem_rd_count", 32'(mem_rd_cnt - rd_base), 32'(3));

        // Reset pulse during the address phase; the rest of that frame is ignored.
        rd_base = mem_rd_cnt;
        cs_low();
        spi_byte(8'h03, 1'b0); spi_byte(8'h00, 1'b0);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        check_idle_outputs("midrst");
        chk("midrst_mem_rd", 32'(mem_rd), 32'(0));
        chk("midrst_mem_addr", 32'(mem_addr), 32'(0));
        oe_hits = 0;
        ign_win = 1'b1;
        spi_byte(8'h00, 1'b0); spi_byte(8'h20, 1'b0); spi_byte(8'h00, 1'b0);
        ign_win = 1'b0;
        chk("midrst_no_mem_rd", 32'(mem_rd_cnt - rd_base), 32'(0));
        chk("midrst_oe_hits", 32'(oe_hits), 32'(0));
        idle_gap();
        status = 8'h5A;
        exp_rx_q.push_back(8'h5A);
        cs_low();
        spi_byte(8'h05, 1'b0);
        rx_en = 1'b1;
        spi_byte(8'h00, 1'b1);
        idle_gap();

        // READ across the top of the address space.
        exp_rx_q.push_back(8'hFE); exp_rx_q.push_back(8'hFF); exp_rx_q.push_back(8'h00);
        exp_addr_q.push_back(24'hFFFFFE); exp_addr_q.push_back(24'hFFFFFF);
        exp_addr_q.push_back(24'h000000);
        cs_low();
        spi_byte(8'h03, 1'b0); spi_byte(8'hFF, 1'b0);
        spi_byte(8'hFF, 1'b0); spi_byte(8'hFE, 1'b0);
        rx_en = 1'b1;
        spi_byte(8'h00, 1'b0); spi_byte(8'h00, 1'b0); spi_byte(8'h00, 1'b1);
        idle_gap();

        // Unknown opcode: output never enabled.
        oe_hits = 0;
        ign_win = 1'b1;
        cs_low();
        spi_byte(8'hAB, 1'b0); spi_byte(8'h00, 1'b0); spi_byte(8'h00, 1'b1);
        idle_gap();
        ign_win = 1'b0;
        chk("unknown_oe_hits", 32'(oe_hits), 32'(0));

        // Abort after four bits of 9Fh, then a clean JDID.
        cs_low();
        spi_bit(1'b1, 1'b0); spi_bit(1'b0, 1'b0); spi_bit(1'b0, 1'b0); spi_bit(1'b1, 1'b0);
        idle_gap();
        check_idle_outputs("abort");
        exp_rx_q.push_back(8'h01); exp_rx_q.push_back(8'h60); exp_rx_q.push_back(8'h17);
        cs_low();
        spi_byte(8'h9F, 1'b0);
        rx_en = 1'b1;
        spi_byte(8'h00, 1'b0); spi_byte(8'h00, 1'b0); spi_byte(8'h00, 1'b1);
        idle_gap();

        chk("rx_queue_drained", 32'(exp_rx_q.size()), 32'(0));
        chk("addr_queue_drained", 32'(exp_addr_q.size()), 32'(0));

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
